// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV64I multicycle state register and control decoder
// Optional build macro UC_RETIRE_CNT_EN enables the retired-instruction counter.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             flag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic [1:0]       aluop,
    output logic             Mux1,
    output logic [1:0]       Mux2,
    output logic             Mux4,
    output logic             pc_sel,
    output logic             weMem,
    output logic             weReg,
    output logic             weIR,
    output logic             wePc,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_TRAP   = 4'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t        state_q, state_d;
    logic [6:0]    opcode_q, opcode_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [WW-1:0] wait_inc;
    logic          legal;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, taken;

    assign is_r    = (opcode_q == OP_R);
    assign is_i    = (opcode_q == OP_I);
    assign is_ld   = (opcode_q == OP_LD);
    assign is_st   = (opcode_q == OP_ST);
    assign is_br   = (opcode_q == OP_BR);
    assign is_jal  = (opcode_q == OP_JAL);
    assign is_jalr = (opcode_q == OP_JALR);
    assign taken   = funct3_q[0] ? ~flag : flag;
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_JALR: legal = 1'b1;
            OP_BR:   legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wait_d    = wait_q;
        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    wait_d = '0;
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else if (is_ld)         state_d = S_WB;
                    else                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_inc;
                    // Completion wins over timeout when both land on the same cycle.
                    if (wait_inc == WW'(MEM_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                funct3_d = funct3;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                wait_d = '0;
                if (is_br)              state_d = S_FETCH;
                else if (is_ld || is_st) state_d = S_MEM;
                else                    state_d = S_WB;
            end
            S_WB: begin
                wait_d  = '0;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RST;
            opcode_q  <= '0;
            funct3_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
        end
    end

    // Decoded straight from state_q so the asynchronous reset kills every enable at once.
    always_comb begin
        mem_req = 1'b0;
        aluop   = 2'b00;
        Mux1    = 1'b0;
        Mux2    = 2'b00;
        Mux4    = 1'b0;
        pc_sel  = 1'b0;
        weMem   = 1'b0;
        weReg   = 1'b0;
        weIR    = 1'b0;
        wePc    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                weIR    = mem_ready;
            end
            S_EXEC: begin
                if (is_r) begin
                    aluop = 2'b10;
                end else if (is_i) begin
                    aluop = 2'b11;
                    Mux1  = 1'b1;
                end else if (is_ld || is_st) begin
                    Mux1 = 1'b1;
                end else if (is_br) begin
                    aluop  = 2'b01;
                    Mux4   = 1'b1;
                    wePc   = 1'b1;
                    pc_sel = taken;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                Mux1    = 1'b1;
                weMem   = is_st;
                wePc    = is_st & mem_ready;
            end
            S_WB: begin
                weReg = 1'b1;
                wePc  = 1'b1;
                if (is_r || is_i) begin
                    Mux2 = 2'b01;
                end else if (is_jal || is_jalr) begin
                    Mux2   = 2'b10;
                    pc_sel = 1'b1;
                    Mux4   = is_jal;
                end
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

`ifdef UC_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (wePc) retired_d = retired_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif
endmodule
